counter_slot_scheduler: RTL
===========================

# counter_slot_scheduler

Time-shares a single modulo up-counter between N_REQ requesters. Each requester asks for a counting slot with its own terminal count. A round-robin arbiter grants one requester at a time, and the block sequences the counter from 0 up to that terminal count. When the run finishes it signals completion, or abort if the requester withdraws. It sits between client state machines and the shared counter datapath, replacing per-client hardcoded modulo counters.

## Interface
- N_REQ, default 4: number of requesters; legal range 2..8.
- BITS, default 4: counter and terminal-count width.
- clk, input, 1: clock; all state updates on rising edge.
- reset_n, input, 1: reset, asynchronous, active-low.
- req, input, N_REQ: per-requester request level; held high for the whole slot.
- len, input, N_REQ*BITS: per-requester terminal count; requester i uses bits [i*BITS +: BITS].
- grant, output, N_REQ: one-hot owner of the counter; all-zero when idle.
- count, output, BITS: current counter value.
- busy, output, 1: high whenever the state is not IDLE.
- done, output, N_REQ: one-hot, one-cycle pulse to the requester whose run completed.
- aborted, output, N_REQ: one-hot, one-cycle pulse to the requester whose run was cancelled.

## Operation
- State machine: IDLE, RUN, DONE. Registered internals:
  - ptr: round-robin pointer, clog2(N_REQ) bits.
  - win: winner index.
  - len_q: latched terminal count.
- IDLE:
  - grant=0, count=0.
  - If req != 0, select the first set req bit scanning circularly from ptr upward.
  - Next state RUN; grant<=onehot(win); len_q<=len[win]; count<=0.
- RUN:
  - Abort: if req[win]==0, go to IDLE. grant<=0, aborted[win] pulses one cycle, count<=0, ptr<=(win+1) mod N_REQ.
  - Completion: else if count==len_q, go to DONE. done[win] pulses during the DONE cycle, grant and count hold.
  - Otherwise count<=count+1.
- DONE: next state IDLE; grant<=0; count<=0; ptr<=(win+1) mod N_REQ.
- Abort has priority over completion when both occur in the same cycle.
- len_q is latched once at grant. Changes to len during RUN are ignored.
- count never exceeds len_q. There is no wrap within a slot. len_q = 2^BITS-1 is legal and reaches the all-ones value.
- Requests from non-granted requesters are ignored until the FSM returns to IDLE. A requester need not drop req after done; it is re-eligible per round-robin order.
- grant, done and aborted are always one-hot or zero. done and aborted are never both set in the same cycle.

## Timing
- Reset values: grant=0, count=0, busy=0, done=0, aborted=0, ptr=0, state IDLE.
- Reset is asynchronous and takes effect mid-slot: no done or aborted pulse is emitted for the interrupted slot.
- Grant latency: req sampled high in IDLE at edge k gives grant and busy high after edge k (cycle k+1), with count=0.
- Slot length: RUN lasts len_q+1 cycles (count 0..len_q), then 1 DONE cycle. Total occupancy is len_q+3 cycles, including the IDLE arbitration cycle.
- Back-to-back slots are separated by exactly one IDLE cycle.
- Abort response: req[win] low in RUN at edge k gives grant=0 and the aborted pulse in cycle k+1.

## Test plan
- Single slot: req=4'b0001, len0=3.
  - grant=0001 for 5 cycles, count 0,1,2,3,3.
  - done=0001 on the 5th cycle only; busy drops next cycle.
- Round-robin: req=4'b1111 held, all len=1, from reset.
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Each slot is 4 cycles, with one IDLE cycle between slots.
- Zero length: req[2] only, len2=0.
  - RUN 1 cycle with count=0, then done=0100.
  - Total grant duration 2 cycles.
- Abort: req[1], len1=9; drop req[1] when count=4.
  - Next cycle: grant=0, aborted=0010, count=0, no done.
  - Next winner is searched starting at index 2.
- Maximum length with mid-run change: BITS=4, len=15, and len changed to 2 during RUN.
  - count reaches 15, with no wrap or early stop.
  - done asserts after 16 RUN cycles.
- Reset mid-slot: assert reset_n low at count=5.
  - All outputs 0 immediately (asynchronously).
  - After release with req=1010, grant=0010 because ptr was reset to 0.

Source files
------------

// File: rtl/counter_slot_scheduler.sv
// Round-robin scheduler that lends one shared modulo up-counter to N_REQ requesters.
// Grant one cycle after arbitration; a slot runs count 0..len_q, then one DONE cycle.
module counter_slot_scheduler #(
   parameter int N_REQ = 4,
   parameter int BITS  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*BITS-1:0] len,
   output logic [N_REQ-1:0]      grant,
   output logic [BITS-1:0]       count,
   output logic                  busy,
   output logic [N_REQ-1:0]      done,
   output logic [N_REQ-1:0]      aborted
);
   localparam int PW = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win;
   logic [PW-1:0]   win_inc;
   logic [PW-1:0]   pick;
   logic            pick_vld;
   logic [BITS-1:0] len_q;
   logic            win_req;
   logic            at_end;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= N_REQ) s = s - N_REQ;
      return PW'(s);
   endfunction

   assign win_req = req[win];
   assign at_end  = (count == len_q);
   assign win_inc = wrap_add(win, 1);

   // Walk downward so the last hit, i.e. the nearest index at or above ptr, wins.
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[wrap_add(ptr, i)]) begin
            pick_vld = 1'b1;
            pick     = wrap_add(ptr, i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_vld) state_nxt = RUN;
         RUN: begin
            if (!win_req)    state_nxt = IDLE;
            else if (at_end) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE) ? (ONE << win) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant   <= '0;
         count   <= '0;
         aborted <= '0;
         ptr     <= '0;
         win     <= '0;
         len_q   <= '0;
      end else begin
         aborted <= '0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  win   <= pick;
                  grant <= ONE << pick;
                  len_q <= len[int'(pick)*BITS +: BITS];
                  count <= '0;
               end
            end
            RUN: begin
               // A withdrawn request cancels the slot even on its final count.
               if (!win_req) begin
                  grant   <= '0;
                  aborted <= ONE << win;
                  count   <= '0;
                  ptr     <= win_inc;
               end else if (!at_end) begin
                  count <= count + BITS'(1);
               end
            end
            DONE: begin
               grant <= '0;
               count <= '0;
               ptr   <= win_inc;
            end
            default: ;
         endcase
      end
   end

endmodule
